// File: rtl/shift_sequencer_if.sv
// ============================================================================
// shift_sequencer_if : request/done handshake bundle for shift_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             start;
  logic [1:0]       op;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] operand;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, amount, operand, abort,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, op, amount, operand, abort,
    output ready, busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// shift_sequencer : applies one single-bit shift per clock until amount is spent
// Revision 1.0
// ============================================================================
`default_nettype none

module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] c_OP_SLL = 2'b00;
  localparam logic [1:0] c_OP_SRL = 2'b01;
  localparam logic [1:0] c_OP_SRA = 2'b10;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;

  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] o,
                                                 input logic [WIDTH-1:0] r);
    case (o)
      c_OP_SLL: shift_one = {r[WIDTH-2:0], 1'b0};
      c_OP_SRL: shift_one = {1'b0, r[WIDTH-1:1]};
      c_OP_SRA: shift_one = {r[WIDTH-1], r[WIDTH-1:1]};
      default:  shift_one = {r[WIDTH-2:0], r[WIDTH-1]};
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    case (state_q)
      S_IDLE: begin
        // abort has priority over a simultaneous start
        if (bus.start && !bus.abort) begin
          result_d = bus.operand;
          op_d     = bus.op;
          count_d  = bus.amount;
          state_d  = (bus.amount != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          result_d = shift_one(op_q, result_q);
          count_d  = count_q - AMT_W'(1);
          if (count_q == AMT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready  = (state_q == S_IDLE);
  assign bus.busy   = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// tb_shift_sequencer : directed, self-checking bench with a timeline reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_shift_sequencer;
  localparam int W = 16;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W), .AMT_W(A)) bus_if();
  shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Whole-operation result computed directly from the op definitions
  function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input logic [W-1:0] v, input int amt);
    case (o)
      2'b00: ref_shift = v << amt;
      2'b01: ref_shift = v >> amt;
      2'b10: ref_shift = $unsigned($signed(v) >>> amt);
      default: ref_shift = (amt == 0) ? v : ((v << amt) | (v >> (W - amt)));
    endcase
  endfunction

  // Timeline model: an accepted op occupies cycles [accept .. accept+amount], done in the last
  int n = 0;
  bit m_busy = 1'b0;
  int m_done_at = 0;
  bit m_known = 1'b1;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_exp = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_known = 1'b1;
      m_res   = '0;
    end else begin
      int prev;
      prev = n;
      n++;
      if (!m_busy) begin
        if (bus_if.start && !bus_if.abort) begin
          m_exp     = ref_shift(bus_if.op, bus_if.operand, int'(bus_if.amount));
          m_done_at = n + int'(bus_if.amount);
          m_busy    = 1'b1;
          m_known   = 1'b0;
        end
      end else if (prev == m_done_at) begin
        m_busy  = 1'b0;
        m_known = 1'b1;
        m_res   = m_exp;
      end else if (bus_if.abort) begin
        m_busy  = 1'b0;
        m_known = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_done;
      exp_done = m_busy && (n == m_done_at);
      check("ready", bus_if.ready, !m_busy);
      check("busy", bus_if.busy, m_busy);
      check("done", bus_if.done, exp_done);
      if (exp_done) check("result_at_done", bus_if.result, m_exp);
      else if (!m_busy && m_known) check("result_hold", bus_if.result, m_res);
    end
  end

  task automatic do_op(input logic [1:0] o, input int amt, input logic [W-1:0] opnd,
                       input logic [W-1:0] lit, input int lat_exp);
    int lat;
    lat = 0;
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.op = o; bus_if.amount = A'(amt); bus_if.operand = opnd;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus_if.done) begin
        lat = k;
        break;
      end
      @(posedge clk);
    end
    check("latency", lat, lat_exp);
    check("result_literal", bus_if.result, lit);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.start = 1'b0; bus_if.op = 2'b00; bus_if.amount = '0;
    bus_if.operand = '0; bus_if.abort = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus_if.ready, 1'b1);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    check("rst_result", bus_if.result, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;

    do_op(2'b00, 4,  16'h0001, 16'h0010, 5);
    do_op(2'b10, 15, 16'h8000, 16'hFFFF, 16);
    do_op(2'b01, 15, 16'h8000, 16'h0001, 16);
    do_op(2'b11, 1,  16'h8001, 16'h0003, 2);
    do_op(2'b00, 0,  16'hABCD, 16'hABCD, 1);
    do_op(2'b10, 3,  16'h7F00, 16'h0FE0, 4);
    do_op(2'b00, 15, 16'hABCD, 16'h8000, 16);
    // back-to-back pair: second start lands in the cycle after done
    do_op(2'b01, 3,  16'hF0F0, 16'h1E1E, 4);
    do_op(2'b11, 4,  16'h1234, 16'h2341, 5);

    // start ignored while busy, then abort mid-shift
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.amount = 4'd8; bus_if.operand = 16'h00FF;
    @(posedge clk); #1 bus_if.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.amount = 4'd1; bus_if.operand = 16'h1111;
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.abort = 1'b1;
    @(negedge clk);
    check("abort_busy_c4", bus_if.busy, 1'b1);
    @(posedge clk); #1 bus_if.abort = 1'b0;
    @(negedge clk);
    check("abort_ready_c5", bus_if.ready, 1'b1);
    check("abort_no_done", bus_if.done, 1'b0);
    repeat (3) @(posedge clk);

    // abort together with start in IDLE
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.abort = 1'b1; bus_if.amount = 4'd2;
    @(posedge clk); #1;
    bus_if.start = 1'b0; bus_if.abort = 1'b0;
    @(negedge clk);
    check("abort_start_ready", bus_if.ready, 1'b1);
    check("abort_start_busy", bus_if.busy, 1'b0);

    // abort in DONE still pulses done
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.amount = 4'd2; bus_if.operand = 16'h0005;
    @(posedge clk); #1 bus_if.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 bus_if.abort = 1'b1;
    @(negedge clk);
    check("abort_in_done_pulse", bus_if.done, 1'b1);
    check("abort_in_done_result", bus_if.result, 16'h0014);
    @(posedge clk); #1 bus_if.abort = 1'b0;
    @(negedge clk);
    check("after_done_ready", bus_if.ready, 1'b1);

    // asynchronous reset mid-shift
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.op = 2'b00; bus_if.amount = 4'd10; bus_if.operand = 16'h0003;
    @(posedge clk); #1 bus_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", bus_if.ready, 1'b1);
    check("midrst_busy", bus_if.busy, 1'b0);
    check("midrst_done", bus_if.done, 1'b0);
    check("midrst_result", bus_if.result, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;
    do_op(2'b00, 2, 16'h0003, 16'h000C, 3);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
